spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI NOR flash responder: READ, PP, BE, RDSR, RDID, WREN, WRDI.
// SPI pins are oversampled on CLK_100M through 2-flop synchronizers.
module spi_flash_responder #(
  parameter int          MEM_AW       = 10,
  parameter int          PROG_CYCLES  = 200,
  parameter int          ERASE_CYCLES = 2000,
  parameter logic [23:0] JEDEC_ID     = 24'h20BA18
) (
  input  logic CLK_100M,
  input  logic RESET,
  input  logic S,
  input  logic C_,
  input  logic DQ0,
  output logic DQ1,
  output logic DQ1_OE
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int BMAX  = (PROG_CYCLES > ERASE_CYCLES) ?
                         PROG_CYCLES : ERASE_CYCLES;
  localparam int BW    = $clog2(BMAX + 1);

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_BE   = 8'hC7;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DOUT, DIN, WAIT_CS
  } state_t;

  state_t state, state_n;

  logic [1:0] s_ff, c_ff, d_ff;
  logic       s_s, c_s, d_s;
  logic       s_prev, c_prev, armed;
  logic       s_fall, s_rise, c_rise, c_fall;

  logic [2:0]        bitcnt;
  logic [6:0]        rxsh;
  logic [7:0]        byte_in;
  logic              byte_done;
  logic [7:0]        opcode;
  logic [MEM_AW-1:0] addr;
  logic [1:0]        bytecnt;
  logic [7:0]        shreg;
  logic [7:0]        tx_byte;
  logic              dout_load;
  logic              extra, wrote;

  logic              wip, wel;
  logic [BW-1:0]     busy;
  logic              erasing;
  logic [MEM_AW-1:0] eptr;
  logic [7:0]        status;

  logic [7:0]        mem [DEPTH] = '{default: 8'hFF};
  logic              pp_wr;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_wa;
  logic [7:0]        mem_wd;

  assign s_s = s_ff[1];
  assign c_s = c_ff[1];
  assign d_s = d_ff[1];

  // S edges count only once S has been seen high after reset
  assign s_fall = armed & s_prev & ~s_s;
  assign s_rise = armed & ~s_prev & s_s;
  assign c_rise = ~c_prev & c_s & ~s_s & (state != IDLE);
  assign c_fall = c_prev & ~c_s & ~s_s;

  assign byte_in   = {rxsh, d_s};
  assign byte_done = c_rise & (bitcnt == 3'd7);
  assign dout_load = (state == DOUT) & c_fall & (bitcnt == 3'd0);
  assign status    = {6'b0, wel, wip};
  assign pp_wr     = (state == DIN) & byte_done & wel & ~wip;

  assign DQ1    = shreg[7];
  assign DQ1_OE = (state == DOUT) & ~s_s;

  // synchronize SPI pins and keep previous values for edge detect
  always_ff @(posedge CLK_100M or posedge RESET) begin
    if (RESET) begin
      s_ff   <= 2'b00;
      c_ff   <= 2'b00;
      d_ff   <= 2'b00;
      s_prev <= 1'b0;
      c_prev <= 1'b0;
      armed  <= 1'b0;
    end else begin
      s_ff   <= {s_ff[0], S};
      c_ff   <= {c_ff[0], C_};
      d_ff   <= {d_ff[0], DQ0};
      s_prev <= s_s;
      c_prev <= c_s;
      if (s_s) armed <= 1'b1;
    end
  end

  // transaction state register
  always_ff @(posedge CLK_100M or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  // next-state decode; S rising always returns to IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (s_fall) state_n = CMD;
      CMD: if (byte_done) begin
        unique case (1'b1)
          byte_in == OP_READ:           state_n = ADDR;
          byte_in == OP_PP && !wip:     state_n = ADDR;
          byte_in == OP_RDID:           state_n = DOUT;
          byte_in == OP_RDSR:           state_n = DOUT;
          default:                      state_n = WAIT_CS;
        endcase
      end
      ADDR: if (byte_done && bytecnt == 2'd2)
        state_n = (opcode == OP_READ) ? DOUT : DIN;
      default: state_n = state;
    endcase
    if (s_rise) state_n = IDLE;
  end

  // next outgoing byte for the current opcode
  always_comb begin
    tx_byte = 8'h00;
    unique case (1'b1)
      opcode == OP_RDSR: tx_byte = status;
      opcode == OP_RDID: begin
        case (bytecnt)
          2'd0:    tx_byte = JEDEC_ID[23:16];
          2'd1:    tx_byte = JEDEC_ID[15:8];
          2'd2:    tx_byte = JEDEC_ID[7:0];
          default: tx_byte = 8'h00;
        endcase
      end
      opcode == OP_READ: tx_byte = wip ? 8'hFF : mem[addr];
      default:           tx_byte = 8'h00;
    endcase
  end

  // shift in bits, collect opcode/address, shift out data
  always_ff @(posedge CLK_100M or posedge RESET) begin
    if (RESET) begin
      bitcnt  <= 3'd0;
      rxsh    <= 7'd0;
      opcode  <= 8'h00;
      addr    <= '0;
      bytecnt <= 2'd0;
      shreg   <= 8'h00;
      extra   <= 1'b0;
      wrote   <= 1'b0;
    end else begin
      if (s_s)         bitcnt <= 3'd0;
      else if (c_rise) bitcnt <= bitcnt + 3'd1;
      if (c_rise) rxsh <= byte_in[6:0];
      if (state == CMD && byte_done) opcode <= byte_in;
      if (state != state_n)
        bytecnt <= 2'd0;
      else if (state == ADDR && byte_done)
        bytecnt <= bytecnt + 2'd1;
      else if (dout_load && bytecnt != 2'd3)
        bytecnt <= bytecnt + 2'd1;
      if (state == ADDR && c_rise)
        addr <= {addr[MEM_AW-2:0], d_s};
      else if (pp_wr)
        addr[7:0] <= addr[7:0] + 8'd1;
      else if (dout_load && opcode == OP_READ)
        addr <= addr + 1'b1;
      if (s_fall) begin
        extra <= 1'b0;
        wrote <= 1'b0;
        shreg <= 8'h00;
      end else if (state == DOUT && c_fall) begin
        shreg <= (bitcnt == 3'd0) ? tx_byte : {shreg[6:0], 1'b0};
      end
      if (state == WAIT_CS && c_rise) extra <= 1'b1;
      if (pp_wr) wrote <= 1'b1;
    end
  end

  // status bits, busy timer, and commands committed on S rising
  always_ff @(posedge CLK_100M or posedge RESET) begin
    if (RESET) begin
      wip     <= 1'b0;
      wel     <= 1'b0;
      busy    <= '0;
      erasing <= 1'b0;
      eptr    <= '0;
    end else begin
      if (wip) begin
        if (busy <= BW'(1)) begin
          busy <= '0;
          wip  <= 1'b0;
          wel  <= 1'b0;
        end else begin
          busy <= busy - 1'b1;
        end
      end
      if (erasing) begin
        eptr <= eptr + 1'b1;
        if (eptr == '1) erasing <= 1'b0;
      end
      if (s_rise && wrote) begin
        wip  <= 1'b1;
        busy <= BW'(PROG_CYCLES);
      end
      if (s_rise && state == WAIT_CS && !extra && !wip) begin
        unique case (1'b1)
          opcode == OP_WREN: wel <= 1'b1;
          opcode == OP_WRDI: wel <= 1'b0;
          opcode == OP_BE && wel: begin
            wip     <= 1'b1;
            busy    <= BW'(ERASE_CYCLES);
            erasing <= 1'b1;
            eptr    <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // single write port shared by erase sweep and page program
  always_comb begin
    mem_we = pp_wr;
    mem_wa = addr;
    mem_wd = mem[addr] & byte_in;
    if (erasing) begin
      mem_we = 1'b1;
      mem_wa = eptr;
      mem_wd = 8'hFF;
    end
  end

  // array contents survive RESET
  always_ff @(posedge CLK_100M) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: directed SPI transactions,
// expected DQ1 bytes queued and checked by a bit-level monitor.
module tb_spi_flash_responder;

  logic clk = 1'b0;
  logic RESET, S, C_, DQ0;
  logic DQ1, DQ1_OE;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mshift = 8'h00;
  int mcnt = 0;

  spi_flash_responder dut (
    .CLK_100M(clk),
    .RESET(RESET),
    .S(S),
    .C_(C_),
    .DQ0(DQ0),
    .DQ1(DQ1),
    .DQ1_OE(DQ1_OE)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // capture DQ1 on master sampling edges while the DUT drives
  always @(posedge C_ or posedge S) begin
    if (S) begin
      mcnt = 0;
    end else if (DQ1_OE) begin
      mshift = {mshift[6:0], DQ1};
      mcnt++;
      if (mcnt == 8) begin
        mcnt = 0;
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_byte: got %02h required none",
                   mshift);
        end else begin
          check("dq1_byte", {24'h0, mshift}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ex(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic sbit(input logic b);
    DQ0 = b;
    tick(8);
    C_ = 1'b1;
    tick(8);
    C_ = 1'b0;
  endtask

  task automatic sbyte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sbit(b[i]);
  endtask

  task automatic sbyte_oe_off(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      check("oe_in_opcode", {31'h0, DQ1_OE}, 32'h0);
      sbit(b[i]);
    end
  endtask

  task automatic cs_lo;
    S = 1'b0;
    tick(16);
  endtask

  task automatic cs_hi;
    tick(8);
    S = 1'b1;
    tick(16);
  endtask

  task automatic cmd(input logic [7:0] op);
    cs_lo;
    sbyte(op);
    cs_hi;
  endtask

  task automatic rdsr(input int n);
    cs_lo;
    sbyte(8'h05);
    repeat (n) sbyte(8'h00);
    cs_hi;
  endtask

  task automatic rd(input logic [23:0] a, input int n);
    cs_lo;
    sbyte(8'h03);
    sbyte(a[23:16]);
    sbyte(a[15:8]);
    sbyte(a[7:0]);
    repeat (n) sbyte(8'h00);
    cs_hi;
  endtask

  task automatic pp_open(input logic [23:0] a);
    cs_lo;
    sbyte(8'h02);
    sbyte(a[23:16]);
    sbyte(a[15:8]);
    sbyte(a[7:0]);
  endtask

  initial begin
    repeat (300000) @(posedge clk);
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    S     = 1'b1;
    C_    = 1'b0;
    DQ0   = 1'b0;
    tick(5);
    check("rst_oe", {31'h0, DQ1_OE}, 32'h0);
    check("rst_dq1", {31'h0, DQ1}, 32'h0);
    RESET = 1'b0;
    tick(10);

    // identification, opcode phase undriven
    ex(8'h20); ex(8'hBA); ex(8'h18); ex(8'h00);
    cs_lo;
    sbyte_oe_off(8'h9F);
    repeat (4) sbyte(8'h00);
    cs_hi;

    // status after reset, WREN then WRDI
    ex(8'h00); rdsr(1);
    cmd(8'h06);
    ex(8'h02); rdsr(1);
    cmd(8'h04);
    ex(8'h00); rdsr(1);

    // WREN with a ninth bit is ignored
    cs_lo;
    sbyte(8'h06);
    sbit(1'b0);
    cs_hi;
    ex(8'h00); rdsr(1);

    // page program across page end, live status while busy
    cmd(8'h06);
    pp_open(24'h0000FE);
    sbyte(8'h11); sbyte(8'h22); sbyte(8'h33);
    cs_hi;
    ex(8'h03); ex(8'h00); ex(8'h00); rdsr(3);
    ex(8'h11); ex(8'h22); ex(8'hFF); rd(24'h0000FE, 3);
    ex(8'h33); rd(24'h000000, 1);

    // program without WREN writes nothing
    pp_open(24'h000010);
    sbyte(8'h00);
    cs_hi;
    ex(8'hFF); rd(24'h000010, 1);
    ex(8'h00); rdsr(1);

    // AND semantics, then bulk erase
    cmd(8'h06);
    pp_open(24'h000020); sbyte(8'hF0); cs_hi;
    tick(250);
    cmd(8'h06);
    pp_open(24'h000020); sbyte(8'h0F); cs_hi;
    tick(250);
    ex(8'h00); rd(24'h000020, 1);
    cmd(8'h06);
    cmd(8'hC7);
    ex(8'h03); rdsr(1);
    tick(2100);
    ex(8'h00); rdsr(1);
    ex(8'hFF); rd(24'h000020, 1);
    ex(8'hFF); ex(8'hFF); rd(24'h0000FE, 2);
    ex(8'hFF); rd(24'h000000, 1);

    // abort mid-byte keeps only the completed byte
    cmd(8'h06);
    pp_open(24'h000000);
    sbyte(8'h55);
    repeat (4) sbit(1'b0);
    cs_hi;
    tick(250);
    ex(8'h55); ex(8'hFF); rd(24'h000000, 2);
    ex(8'h00); rdsr(1);

    // array wrap and ignored upper address bits
    cmd(8'h06);
    pp_open(24'h0003FF);
    sbyte(8'hA5); sbyte(8'h5A);
    cs_hi;
    tick(250);
    ex(8'hA5); ex(8'h55); rd(24'hFC03FF, 2);
    ex(8'h5A); rd(24'h000300, 1);

    // busy erase: READ gives FF, WRDI ignored, then RESET
    cmd(8'h06);
    cmd(8'hC7);
    ex(8'hFF); rd(24'h0003FF, 1);
    cmd(8'h04);
    ex(8'h03); rdsr(1);
    RESET = 1'b1;
    tick(3);
    check("rst_busy_oe", {31'h0, DQ1_OE}, 32'h0);
    check("rst_busy_dq1", {31'h0, DQ1}, 32'h0);
    RESET = 1'b0;
    tick(10);
    ex(8'h00); rdsr(1);
    ex(8'h20); ex(8'hBA); ex(8'h18);
    cs_lo;
    sbyte(8'h9F);
    repeat (3) sbyte(8'h00);
    cs_hi;

    tick(20);
    check("pending_bytes", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
